// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core: architectural state commits on the falling edge of clock,
// decode/execute are combinational from the instruction latched by imem on that edge.
module rv32i_cpu (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemdataout,
  output logic        imemclk,
  output logic [31:0] dmemaddr,
  input  logic [31:0] dmemdataout,
  output logic [31:0] dmemdatain,
  output logic        dmemrdclk,
  output logic        dmemwrclk,
  output logic [2:0]  dmemop,
  output logic        dmemwe,
  output logic [31:0] dbgdata
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] alu_b, alu_y;
  logic [2:0]  alu_f3;
  logic [4:0]  shamt;
  logic        br_taken;
  logic        rd_we;
  logic        is_store;
  logic [31:0] wb_val;

  assign instr  = imemdataout;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is cleared by reset and never written, so it always reads zero
  assign rs1_val = regs_q[rs1];
  assign rs2_val = regs_q[rs2];

  // Loads, stores and JALR reuse the adder path (funct3 forced to ADD)
  always_comb begin
    alu_b  = (opcode == OP_OP) ? rs2_val : ((opcode == OP_STORE) ? imm_s : imm_i);
    alu_f3 = ((opcode == OP_OP) || (opcode == OP_IMM)) ? funct3 : 3'b000;
    shamt  = alu_b[4:0];
    case (alu_f3)
      3'b000:  alu_y = ((opcode == OP_OP) && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_y = rs1_val << shamt;
      3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_y = {31'b0, rs1_val < alu_b};
      3'b100:  alu_y = rs1_val ^ alu_b;
      3'b101:  alu_y = instr[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110:  alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q + 32'd4;
    rd_we    = 1'b0;
    is_store = 1'b0;
    wb_val   = alu_y;
    dmemop   = 3'b010;
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; wb_val = imm_u; end
      OP_AUIPC:  begin rd_we = 1'b1; wb_val = pc_q + imm_u; end
      OP_JAL:    begin rd_we = 1'b1; wb_val = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JALR:   begin rd_we = 1'b1; wb_val = pc_q + 32'd4; pc_d = alu_y & ~32'd1; end
      OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; wb_val = dmemdataout; dmemop = funct3; end
      OP_STORE:  begin is_store = 1'b1; dmemop = funct3; end
      OP_IMM, OP_OP: rd_we = 1'b1;
      default: ;
    endcase
  end

  // Reset must gate the fetch address and write strobe without waiting for a clock edge
  assign imemaddr   = reset ? 32'd0 : pc_d;
  assign dmemwe     = is_store & ~reset;
  assign dmemaddr   = alu_y;
  assign dmemdatain = rs2_val;
  assign imemclk    = ~clock;
  assign dmemrdclk  = clock;
  assign dmemwrclk  = ~clock;
  assign dbgdata    = pc_q;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && (rd != 5'd0)) regs_q[rd] <= wb_val;
    end
  end
endmodule

// File: tb/tb_rv32i_cpu.sv
// Bench for rv32i_cpu: external imem/dmem models, an instruction-set model that predicts
// the core's outputs each cycle, and literal checks of the final memory image.
module tb_rv32i_cpu;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imemaddr, imemdataout, dmemaddr, dmemdataout, dmemdatain, dbgdata;
  logic        imemclk, dmemrdclk, dmemwrclk, dmemwe;
  logic [2:0]  dmemop;

  int n_vec = 0;
  int n_err = 0;
  logic checking = 1'b0;
  logic running  = 1'b0;

  rv32i_cpu dut (
    .clock(clock), .reset(reset),
    .imemaddr(imemaddr), .imemdataout(imemdataout), .imemclk(imemclk),
    .dmemaddr(dmemaddr), .dmemdataout(dmemdataout), .dmemdatain(dmemdatain),
    .dmemrdclk(dmemrdclk), .dmemwrclk(dmemwrclk), .dmemop(dmemop),
    .dmemwe(dmemwe), .dbgdata(dbgdata)
  );

  always #5 clock = ~clock;

  // ---------------- environment memories ----------------
  logic [31:0] prog [0:255];
  logic [31:0] imem_q = 32'h0000_0013;
  assign imemdataout = imem_q;
  always @(posedge imemclk) imem_q <= prog[imemaddr[9:2]];

  function automatic logic [31:0] ext_load(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  logic [7:0] dmem [0:255];
  logic       env_init = 1'b0;
  logic [31:0] dmem_rd = 32'h0;
  assign dmemdataout = dmem_rd;

  always @(posedge dmemrdclk) begin
    logic [7:0] a;
    a = dmemaddr[7:0];
    dmem_rd <= ext_load(dmem[a], dmem[8'(a + 8'd1)], dmem[8'(a + 8'd2)], dmem[8'(a + 8'd3)], dmemop);
  end

  always @(posedge dmemwrclk or posedge reset) begin
    logic [7:0] a;
    if (reset) begin
      if (!env_init) begin
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        dmem[8'h40] = 8'h80;
        env_init = 1'b1;
      end
    end else if (dmemwe) begin
      a = dmemaddr[7:0];
      dmem[a] = dmemdatain[7:0];
      if (dmemop != 3'b000) dmem[8'(a + 8'd1)] = dmemdatain[15:8];
      if (dmemop[1:0] == 2'b10) begin
        dmem[8'(a + 8'd2)] = dmemdatain[23:16];
        dmem[8'(a + 8'd3)] = dmemdatain[31:24];
      end
    end
  end

  // ---------------- instruction-set model ----------------
  typedef struct packed {
    logic [31:0] next_pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd_val;
    logic [2:0]  op;
    logic        is_mem;
    logic        we;
    logic        rd_we;
    logic [4:0]  rd;
  } ev_t;

  logic [31:0] iss_pc;
  logic [31:0] iss_x [32];
  logic [7:0]  iss_mem [0:255];
  logic        iss_init = 1'b0;

  function automatic ev_t iss_eval();
    ev_t e;
    logic [31:0] ins, a, b, ii, is_, ib, iu, ij, y;
    logic [2:0] f3;
    logic [7:0] ad;
    logic tk;
    ins = prog[iss_pc[9:2]];
    f3  = ins[14:12];
    a   = iss_x[ins[19:15]];
    b   = iss_x[ins[24:20]];
    ii  = {{20{ins[31]}}, ins[31:20]};
    is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu  = {ins[31:12], 12'h000};
    ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    tk  = 1'b0;
    e = '0;
    e.next_pc = iss_pc + 32'd4;
    e.op = 3'b010;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h37: begin e.rd_we = 1'b1; e.rd_val = iu; end
      7'h17: begin e.rd_we = 1'b1; e.rd_val = iss_pc + iu; end
      7'h6F: begin e.rd_we = 1'b1; e.rd_val = iss_pc + 32'd4; e.next_pc = iss_pc + ij; end
      7'h67: begin e.rd_we = 1'b1; e.rd_val = iss_pc + 32'd4; e.next_pc = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) e.next_pc = iss_pc + ib;
      end
      7'h03: begin
        e.is_mem = 1'b1; e.op = f3; e.addr = a + ii; e.rd_we = 1'b1;
        ad = e.addr[7:0];
        e.rd_val = ext_load(iss_mem[ad], iss_mem[8'(ad + 8'd1)], iss_mem[8'(ad + 8'd2)],
                            iss_mem[8'(ad + 8'd3)], f3);
      end
      7'h23: begin e.is_mem = 1'b1; e.we = 1'b1; e.op = f3; e.addr = a + is_; e.data = b; end
      7'h13, 7'h33: begin
        y = (ins[6:0] == 7'h33) ? b : ii;
        e.rd_we = 1'b1;
        case (f3)
          3'd0: e.rd_val = (ins[6:0] == 7'h33 && ins[30]) ? a - y : a + y;
          3'd1: e.rd_val = a << y[4:0];
          3'd2: e.rd_val = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
          3'd3: e.rd_val = (a < y) ? 32'd1 : 32'd0;
          3'd4: e.rd_val = a ^ y;
          3'd5: e.rd_val = ins[30] ? $unsigned($signed(a) >>> y[4:0]) : a >> y[4:0];
          3'd6: e.rd_val = a | y;
          default: e.rd_val = a & y;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clock or posedge reset) begin
    ev_t e;
    if (reset) begin
      iss_pc = 32'd0;
      for (int i = 0; i < 32; i++) iss_x[i] = 32'd0;
      if (!iss_init) begin
        for (int i = 0; i < 256; i++) iss_mem[i] = 8'h00;
        iss_mem[8'h40] = 8'h80;
        iss_init = 1'b1;
      end
    end else if (running) begin
      e = iss_eval();
      if (e.we) begin
        iss_mem[e.addr[7:0]] = e.data[7:0];
        if (e.op != 3'b000) iss_mem[8'(e.addr[7:0] + 8'd1)] = e.data[15:8];
        if (e.op[1:0] == 2'b10) begin
          iss_mem[8'(e.addr[7:0] + 8'd2)] = e.data[23:16];
          iss_mem[8'(e.addr[7:0] + 8'd3)] = e.data[31:24];
        end
      end
      if (e.rd_we && e.rd != 5'd0) iss_x[e.rd] = e.rd_val;
      iss_pc = e.next_pc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare, after the rising edge so load data is in place
  always @(posedge clock) begin
    ev_t e;
    #2;
    if (checking) begin
      if (reset) begin
        chk("rst_dbgdata", dbgdata, 32'd0);
        chk("rst_imemaddr", imemaddr, 32'd0);
        chk("rst_dmemwe", {31'd0, dmemwe}, 32'd0);
      end else begin
        e = iss_eval();
        $display("pc=%h instr=%h next=%h we=%b addr=%h wdata=%h", dbgdata, imemdataout,
                 imemaddr, dmemwe, dmemaddr, dmemdatain);
        chk("dbgdata", dbgdata, iss_pc);
        chk("imemaddr", imemaddr, e.next_pc);
        chk("dmemwe", {31'd0, dmemwe}, {31'd0, e.we});
        if (e.is_mem) begin
          chk("dmemaddr", dmemaddr, e.addr);
          chk("dmemop", {29'd0, dmemop}, {29'd0, e.op});
        end
        if (e.we) chk("dmemdatain", dmemdatain, e.data);
      end
    end
  end

  // ---------------- program construction ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    prog[addr[9:2]] = w;
  endtask

  logic [31:0] exp_addr [13] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                                 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34};
  logic [31:0] exp_word [13] = '{32'hFFFF_FF80, 32'h0000_0005, 32'h0000_0024, 32'h0000_0080,
                                 32'h0000_0011, 32'h0000_0000, 32'h1234_5000, 32'hF800_0000,
                                 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_1084, 32'h0000_0031,
                                 32'h0000_0024};

  initial begin
    logic [31:0] skip;
    logic [7:0] a;
    skip = enc_i(12'h055, 5'd0, 3'd0, 5'd5, 7'h13);
    for (int i = 0; i < 256; i++) prog[i] = 32'h0000_0013;
    put(32'h00, 32'h0050_0093);                                   // addi x1,x0,5
    put(32'h04, 32'h0010_2423);                                   // sw x1,8(x0)
    put(32'h08, 32'h0010_8863);                                   // beq x1,x1,+16
    put(32'h0C, skip); put(32'h10, skip); put(32'h14, skip);
    put(32'h18, enc_b(13'd16, 5'd1, 5'd1, 3'd1));                 // bne x1,x1,+16
    put(32'h1C, enc_i(12'h040, 5'd0, 3'd0, 5'd2, 7'h03));         // lb x2,0x40(x0)
    put(32'h20, enc_j(21'd12, 5'd1));                             // jal x1,+12
    put(32'h24, skip); put(32'h28, skip);
    put(32'h2C, enc_s(12'd4, 5'd2, 5'd0, 3'd2));                  // sw x2,4
    put(32'h30, enc_s(12'd12, 5'd1, 5'd0, 3'd2));                 // sw x1,12
    put(32'h34, enc_i(12'h040, 5'd0, 3'd4, 5'd3, 7'h03));         // lbu x3,0x40(x0)
    put(32'h38, enc_s(12'd16, 5'd3, 5'd0, 3'd2));                 // sw x3,16
    put(32'h3C, enc_i(12'hFFF, 5'd0, 3'd0, 5'd4, 7'h13));         // addi x4,x0,-1
    put(32'h40, enc_i(12'h001, 5'd0, 3'd0, 5'd6, 7'h13));         // addi x6,x0,1
    put(32'h44, enc_b(13'd8, 5'd6, 5'd4, 3'd4));                  // blt x4,x6,+8
    put(32'h48, skip);
    put(32'h4C, enc_b(13'd8, 5'd6, 5'd4, 3'd6));                  // bltu x4,x6,+8
    put(32'h50, enc_i(12'h011, 5'd0, 3'd0, 5'd7, 7'h13));         // addi x7,x0,0x11
    put(32'h54, enc_s(12'd20, 5'd7, 5'd0, 3'd2));
    put(32'h58, enc_s(12'd24, 5'd5, 5'd0, 3'd2));
    put(32'h5C, enc_u(20'h12345, 5'd3, 7'h37));                   // lui x3,0x12345
    put(32'h60, enc_s(12'd28, 5'd3, 5'd0, 3'd2));
    put(32'h64, enc_u(20'h80000, 5'd8, 7'h37));                   // lui x8,0x80000
    put(32'h68, enc_i(12'h004, 5'd0, 3'd0, 5'd9, 7'h13));         // addi x9,x0,4
    put(32'h6C, enc_r(7'h20, 5'd9, 5'd8, 3'd5, 5'd10));           // sra x10,x8,x9
    put(32'h70, enc_s(12'd32, 5'd10, 5'd0, 3'd2));
    put(32'h74, enc_r(7'h20, 5'd9, 5'd0, 3'd0, 5'd11));           // sub x11,x0,x9
    put(32'h78, enc_s(12'd36, 5'd11, 5'd0, 3'd2));
    put(32'h7C, enc_i(12'h007, 5'd0, 3'd0, 5'd0, 7'h13));         // addi x0,x0,7
    put(32'h80, enc_s(12'd40, 5'd0, 5'd0, 3'd2));
    put(32'h84, enc_u(20'h00001, 5'd12, 7'h17));                  // auipc x12,1
    put(32'h88, enc_s(12'd44, 5'd12, 5'd0, 3'd2));
    put(32'h8C, enc_r(7'h00, 5'd4, 5'd6, 3'd3, 5'd14));           // sltu x14,x6,x4
    put(32'h90, enc_i(12'h005, 5'd14, 3'd1, 5'd15, 7'h13));       // slli x15,x14,5
    put(32'h94, enc_r(7'h00, 5'd7, 5'd15, 3'd6, 5'd16));          // or x16,x15,x7
    put(32'h98, enc_s(12'd48, 5'd16, 5'd0, 3'd2));
    put(32'h9C, 32'h0000_0073);                                   // ecall
    put(32'hA0, 32'h0000_00FF);                                   // unknown opcode, rd=x1
    put(32'hA4, enc_i(12'h100, 5'd0, 3'd0, 5'd17, 7'h13));        // addi x17,x0,0x100
    put(32'hA8, enc_i(12'h003, 5'd17, 3'd0, 5'd0, 7'h67));        // jalr x0,3(x17)
    put(32'h100, enc_s(12'd52, 5'd1, 5'd0, 3'd2));                // sw x1,52 (runs at PC 0x102)
    put(32'h104, enc_j(21'h1FFFFC, 5'd0));                        // jal x0,-4

    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    running = 1'b1;
    #1;
    chk("release_dbgdata", dbgdata, 32'd0);
    chk("release_imemaddr", imemaddr, 32'h4);

    for (int i = 0; i < 300 && iss_pc != 32'h102; i++) begin
      @(negedge clock);
      #1;
    end
    @(negedge clock); #1;
    @(negedge clock); #1;
    chk("loop_pc", dbgdata, 32'h102);

    for (int k = 0; k < 13; k++) begin
      a = exp_addr[k][7:0];
      chk($sformatf("dmem[%0h]", a), {dmem[8'(a + 8'd3)], dmem[8'(a + 8'd2)], dmem[8'(a + 8'd1)], dmem[a]}, exp_word[k]);
      chk($sformatf("model_mem[%0h]", a),
          {iss_mem[8'(a + 8'd3)], iss_mem[8'(a + 8'd2)], iss_mem[8'(a + 8'd1)], iss_mem[a]}, exp_word[k]);
    end

    // Reset in the middle of the store cycle
    @(posedge clock);
    #2 chk("mid_store_we", {31'd0, dmemwe}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_dmemwe", {31'd0, dmemwe}, 32'd0);
    chk("abort_dbgdata", dbgdata, 32'd0);
    chk("abort_imemaddr", imemaddr, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (6) @(posedge clock);
    #3;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
